pong_renderer: RTL and testbench

//  Pixel-generation stage downstream of the game logic: converts paddle/ball coordinates into a
//  per-pixel RGB stream for the VGA output. Sits between the VGA timing generator (pixel x/y,

---
 rtl/pong_pkg.sv | 75 +++++++
 rtl/pong_renderer_rect_hit.sv | 25 ++
 rtl/pong_renderer.sv | 139 +++++++++++++
 tb/tb_pong_renderer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types, colours and screen geometry for the pong pixel pipeline.
// Geometry macros are defaulted here so a build can override them with +define+.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif
`ifndef SCREEN_H_RES
`define SCREEN_H_RES 640
`endif
`ifndef SCREEN_V_RES
`define SCREEN_V_RES 480
`endif
`ifndef SCREEN_BORDER
`define SCREEN_BORDER 3
`endif
`ifndef PADDLE_WIDTH
`define PADDLE_WIDTH 10
`endif
`ifndef PADDLE_HEIGHT
`define PADDLE_HEIGHT 60
`endif
`ifndef BALL_SIDE
`define BALL_SIDE 8
`endif

package pong_pkg;
   localparam int X_W  = `X_POS_W;
   localparam int Y_W  = `Y_POS_W;
   localparam int CH_W = 8;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   // Colours are held at 8 bits per channel; the top keeps the MSBs it needs.
   localparam rgb_t COL_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
   localparam rgb_t COL_WHITE  = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
   localparam rgb_t COL_GREY   = '{r: 8'h80, g: 8'h80, b: 8'h80};
   localparam rgb_t COL_BALL   = COL_WHITE;
   localparam rgb_t COL_PADDLE = COL_WHITE;
   localparam rgb_t COL_BORDER = COL_GREY;
   localparam rgb_t COL_NET    = COL_GREY;
   localparam rgb_t COL_BG     = COL_BLACK;

   typedef enum logic [2:0] {
      OBJ_NONE,
      OBJ_BG,
      OBJ_BORDER,
      OBJ_NET,
      OBJ_PADDLE,
      OBJ_BALL
   } object_id_t;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } obj_pos_t;

   function automatic rgb_t obj_colour(object_id_t id);
      rgb_t c;
      case (id)
         OBJ_BALL:   c = COL_BALL;
         OBJ_PADDLE: c = COL_PADDLE;
         OBJ_BORDER: c = COL_BORDER;
         OBJ_NET:    c = COL_NET;
         OBJ_BG:     c = COL_BG;
         default:    c = COL_BLACK;
      endcase
      return c;
   endfunction
endpackage

// File: rtl/pong_renderer_rect_hit.sv
// Combinational rectangle hit test; bounds are formed one bit wider than the
// position fields so an object near the top of the coordinate range never wraps.
module rect_hit
   import pong_pkg::*;
#(
   parameter int XW = X_W,
   parameter int YW = Y_W,
   parameter int W  = 8,
   parameter int H  = 8
) (
   input  logic [XW-1:0] px,
   input  logic [YW-1:0] py,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   output logic          hit
);
   logic [XW:0] x_end;
   logic [YW:0] y_end;

   assign x_end = {1'b0, x} + (XW+1)'(W);
   assign y_end = {1'b0, y} + (YW+1)'(H);

   assign hit = (px >= x) && ({1'b0, px} < x_end) &&
                (py >= y) && ({1'b0, py} < y_end);
endmodule

// File: rtl/pong_renderer.sv
// Two-stage pixel renderer: frame-latched object positions -> hit flags -> colour.
// Optional dashed centre net is built only when CENTER_NET_EN is defined.
module pong_renderer
   import pong_pkg::*;
#(
   parameter int   RGB_W       = 4,
   parameter logic SYNC_ACTIVE = 1'b0,
   parameter int   NET_DASH    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             new_frame_i,
   input  logic [X_W-1:0]   pixel_x_i,
   input  logic [Y_W-1:0]   pixel_y_i,
   input  logic             video_on_i,
   input  logic             hsync_i,
   input  logic             vsync_i,
   input  logic [X_W-1:0]   player_paddle_x_i,
   input  logic [Y_W-1:0]   player_paddle_y_i,
   input  logic [X_W-1:0]   pc_paddle_x_i,
   input  logic [Y_W-1:0]   pc_paddle_y_i,
   input  logic [X_W-1:0]   ball_x_i,
   input  logic [Y_W-1:0]   ball_y_i,
   output logic [RGB_W-1:0] red_o,
   output logic [RGB_W-1:0] green_o,
   output logic [RGB_W-1:0] blue_o,
   output logic             hsync_o,
   output logic             vsync_o
);
   localparam int STAGES = 2;

   if (NET_DASH < 2 || (NET_DASH & (NET_DASH - 1)) != 0) begin : g_net_dash_chk
      $error("NET_DASH must be a power of two >= 2");
   end

   // Positions are only sampled at the frame strobe so a frame never tears.
   obj_pos_t sh_player, sh_pc, sh_ball;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         sh_player <= '0;
         sh_pc     <= '0;
         sh_ball   <= '0;
      end else if (new_frame_i) begin
         sh_player <= '{x: player_paddle_x_i, y: player_paddle_y_i};
         sh_pc     <= '{x: pc_paddle_x_i,     y: pc_paddle_y_i};
         sh_ball   <= '{x: ball_x_i,          y: ball_y_i};
      end
   end

   logic hit_player, hit_pc, hit_ball, hit_border, hit_net;

   rect_hit #(.W(`PADDLE_WIDTH), .H(`PADDLE_HEIGHT)) u_hit_player (
      .px(pixel_x_i), .py(pixel_y_i), .x(sh_player.x), .y(sh_player.y), .hit(hit_player)
   );
   rect_hit #(.W(`PADDLE_WIDTH), .H(`PADDLE_HEIGHT)) u_hit_pc (
      .px(pixel_x_i), .py(pixel_y_i), .x(sh_pc.x), .y(sh_pc.y), .hit(hit_pc)
   );
   rect_hit #(.W(`BALL_SIDE), .H(`BALL_SIDE)) u_hit_ball (
      .px(pixel_x_i), .py(pixel_y_i), .x(sh_ball.x), .y(sh_ball.y), .hit(hit_ball)
   );

   localparam logic [Y_W-1:0] BORDER_TOP = Y_W'(`SCREEN_BORDER);
   localparam logic [Y_W-1:0] BORDER_BOT = Y_W'(`SCREEN_V_RES - `SCREEN_BORDER);

   assign hit_border = (pixel_y_i < BORDER_TOP) || (pixel_y_i >= BORDER_BOT);

`ifdef CENTER_NET_EN
   localparam int             NET_BIT = $clog2(NET_DASH) - 1;
   localparam logic [X_W-1:0] NET_X0  = X_W'(`SCREEN_H_RES / 2);
   localparam logic [X_W-1:0] NET_X1  = X_W'(`SCREEN_H_RES / 2 + 1);

   // (py % NET_DASH) < NET_DASH/2 reduces to the top bit of the dash slice being 0.
   assign hit_net = ((pixel_x_i == NET_X0) || (pixel_x_i == NET_X1)) && !pixel_y_i[NET_BIT];
`else
   assign hit_net = 1'b0;
`endif

   logic [STAGES:0] vld_pipe;
   assign vld_pipe[0] = 1'b1;

   always_ff @(posedge clk_i) begin
      if (!rst_i) vld_pipe[STAGES:1] <= '0;
      else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   logic s1_ball, s1_paddle, s1_border, s1_net, s1_von, s1_hs, s1_vs;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         s1_ball   <= 1'b0;
         s1_paddle <= 1'b0;
         s1_border <= 1'b0;
         s1_net    <= 1'b0;
         s1_von    <= 1'b0;
         s1_hs     <= ~SYNC_ACTIVE;
         s1_vs     <= ~SYNC_ACTIVE;
      end else begin
         s1_ball   <= hit_ball;
         s1_paddle <= hit_player | hit_pc;
         s1_border <= hit_border;
         s1_net    <= hit_net;
         s1_von    <= video_on_i;
         s1_hs     <= hsync_i;
         s1_vs     <= vsync_i;
      end
   end

   object_id_t obj;
   rgb_t       pix;

   always_comb begin
      obj = OBJ_NONE;
      if (s1_von && vld_pipe[1]) begin
         if (s1_ball)        obj = OBJ_BALL;
         else if (s1_paddle) obj = OBJ_PADDLE;
         else if (s1_border) obj = OBJ_BORDER;
         else if (s1_net)    obj = OBJ_NET;
         else                obj = OBJ_BG;
      end
      pix = obj_colour(obj);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         red_o   <= '0;
         green_o <= '0;
         blue_o  <= '0;
         hsync_o <= ~SYNC_ACTIVE;
         vsync_o <= ~SYNC_ACTIVE;
      end else begin
         red_o   <= pix.r[CH_W-1 -: RGB_W];
         green_o <= pix.g[CH_W-1 -: RGB_W];
         blue_o  <= pix.b[CH_W-1 -: RGB_W];
         hsync_o <= vld_pipe[1] ? s1_hs : ~SYNC_ACTIVE;
         vsync_o <= vld_pipe[1] ? s1_vs : ~SYNC_ACTIVE;
      end
   end
endmodule

// File: tb/tb_pong_renderer.sv
// Scoreboard bench for pong_renderer: stimulus pushes model results tagged with
// their due cycle, a monitor pops and compares them against the DUT outputs.
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif
`ifndef SCREEN_H_RES
`define SCREEN_H_RES 640
`endif
`ifndef SCREEN_V_RES
`define SCREEN_V_RES 480
`endif
`ifndef SCREEN_BORDER
`define SCREEN_BORDER 3
`endif
`ifndef PADDLE_WIDTH
`define PADDLE_WIDTH 10
`endif
`ifndef PADDLE_HEIGHT
`define PADDLE_HEIGHT 60
`endif
`ifndef BALL_SIDE
`define BALL_SIDE 8
`endif

module tb_pong_renderer;
   localparam int XW = `X_POS_W;
   localparam int YW = `Y_POS_W;
   localparam int HRES = `SCREEN_H_RES;
   localparam int VRES = `SCREEN_V_RES;
   localparam int BRD = `SCREEN_BORDER;
   localparam int PW = `PADDLE_WIDTH;
   localparam int PH = `PADDLE_HEIGHT;
   localparam int BS = `BALL_SIDE;
   localparam int NET_DASH = 16;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic new_frame_i = 1'b0;
   logic [XW-1:0] pixel_x_i = '0;
   logic [YW-1:0] pixel_y_i = '0;
   logic video_on_i = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1;
   logic [XW-1:0] player_paddle_x_i = '0, pc_paddle_x_i = '0, ball_x_i = '0;
   logic [YW-1:0] player_paddle_y_i = '0, pc_paddle_y_i = '0, ball_y_i = '0;
   logic [3:0] red_o, green_o, blue_o;
   logic hsync_o, vsync_o;

   pong_renderer dut (
      .clk_i(clk), .rst_i(rst_i), .new_frame_i(new_frame_i),
      .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .video_on_i(video_on_i),
      .hsync_i(hsync_i), .vsync_i(vsync_i),
      .player_paddle_x_i(player_paddle_x_i), .player_paddle_y_i(player_paddle_y_i),
      .pc_paddle_x_i(pc_paddle_x_i), .pc_paddle_y_i(pc_paddle_y_i),
      .ball_x_i(ball_x_i), .ball_y_i(ball_y_i),
      .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
      .hsync_o(hsync_o), .vsync_o(vsync_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         due;
      logic [13:0] val;   // {r,g,b,hsync,vsync}
      string      name;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_fail = 0;
   bit done = 0;

   // Positions the bench wants on the ports, and the model's idea of what is latched.
   int nx_pl_x = 0, nx_pl_y = 0, nx_pc_x = 0, nx_pc_y = 0, nx_b_x = 0, nx_b_y = 0;
   int m_pl_x = 0, m_pl_y = 0, m_pc_x = 0, m_pc_y = 0, m_b_x = 0, m_b_y = 0;

   function automatic bit inside_rect(int px, int py, int x, int y, int w, int h);
      return px >= x && px < x + w && py >= y && py < y + h;
   endfunction

   function automatic logic [11:0] model_rgb(int px, int py, bit von);
      if (!von) return 12'h000;
      if (inside_rect(px, py, m_b_x, m_b_y, BS, BS)) return 12'hFFF;
      if (inside_rect(px, py, m_pl_x, m_pl_y, PW, PH) ||
          inside_rect(px, py, m_pc_x, m_pc_y, PW, PH)) return 12'hFFF;
      if (py < BRD || py >= VRES - BRD) return 12'h888;
`ifdef CENTER_NET_EN
      if ((px == HRES / 2 || px == HRES / 2 + 1) && (py % NET_DASH) < NET_DASH / 2)
         return 12'h888;
`endif
      return 12'h000;
   endfunction

   task automatic check(string name, logic [13:0] act, logic [13:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got rgbhv=%h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic drive(string name, int px, int py, bit von, bit nf);
      exp_t e;
      bit hs, vs;
      @(negedge clk);
      rst_i = 1'b1;
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      pixel_x_i = XW'(px);
      pixel_y_i = YW'(py);
      video_on_i = von;
      hsync_i = hs;
      vsync_i = vs;
      new_frame_i = nf;
      player_paddle_x_i = XW'(nx_pl_x); player_paddle_y_i = YW'(nx_pl_y);
      pc_paddle_x_i = XW'(nx_pc_x);     pc_paddle_y_i = YW'(nx_pc_y);
      ball_x_i = XW'(nx_b_x);           ball_y_i = YW'(nx_b_y);
      e.due = cyc + 2;
      e.val = {model_rgb(px, py, von), hs, vs};
      e.name = name;
      q.push_back(e);
      // A strobe on this pixel takes effect for the next one.
      if (nf) begin
         m_pl_x = nx_pl_x; m_pl_y = nx_pl_y; m_pc_x = nx_pc_x; m_pc_y = nx_pc_y;
         m_b_x = nx_b_x;   m_b_y = nx_b_y;
      end
   endtask

   task automatic strobe();
      drive("strobe", 700, 500, 1'b0, 1'b1);
   endtask

   // Monitor: reset values while reset is low, else pop entries at their due cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (done) break;
         if (!rst_i) begin
            check("reset", {red_o, green_o, blue_o, hsync_o, vsync_o}, 14'b11);
         end else begin
            while (q.size() > 0 && q[0].due <= cyc) begin
               e = q.pop_front();
               if (e.due != cyc) begin
                  n_checks++; n_fail++;
                  $display("FAIL latency %s: due cycle %0d missed at %0d", e.name, e.due, cyc);
               end else begin
                  check(e.name, {red_o, green_o, blue_o, hsync_o, vsync_o}, e.val);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge clk);

      // Ball at (100,100), scan row 101 around it.
      nx_b_x = 100; nx_b_y = 100;
      nx_pl_x = 20; nx_pl_y = 300; nx_pc_x = 600; nx_pc_y = 300;
      strobe();
      for (int x = 97; x <= 100 + BS + 1; x++) drive("ball_row", x, 101, 1'b1, 1'b0);

      // Move ball without a strobe: old position still drawn.
      nx_b_x = 300;
      for (int x = 98; x <= 110; x++) drive("no_strobe", x, 101, 1'b1, 1'b0);
      drive("strobe_visible", 100, 101, 1'b1, 1'b1);
      for (int x = 98; x <= 110; x++) drive("old_gone", x, 101, 1'b1, 1'b0);
      for (int x = 297; x <= 310; x++) drive("new_pos", x, 101, 1'b1, 1'b0);

      // Ball overlapping the player paddle; border pixel; blanked pixel.
      nx_pl_x = 620; nx_pl_y = 200; nx_b_x = 615; nx_b_y = 205;
      strobe();
      for (int x = 612; x <= 632; x++) drive("overlap", x, 210, 1'b1, 1'b0);
      drive("border", 50, 2, 1'b1, 1'b0);
      drive("border_bot", 50, VRES - 1, 1'b1, 1'b0);
      drive("blank", 50, 2, 1'b0, 1'b0);
      drive("blank_ball", 620, 210, 1'b0, 1'b0);

      // Edge objects must not wrap onto row/column 0.
      nx_pl_x = 30; nx_pl_y = VRES - PH; nx_b_x = HRES - 1; nx_b_y = 200;
      strobe();
      for (int x = 28; x <= 42; x++) drive("no_wrap_row0", x, 0, 1'b1, 1'b0);
      for (int x = 0; x <= 4; x++) drive("no_wrap_col0", x, 203, 1'b1, 1'b0);
      drive("edge_ball", HRES - 1, 203, 1'b1, 1'b0);
      drive("edge_paddle", 32, VRES - 1, 1'b1, 1'b0);
      nx_b_x = (1 << XW) - 3; nx_pl_y = (1 << YW) - 5;
      strobe();
      for (int x = 0; x <= 6; x++) drive("no_wrap_max", x, 203, 1'b1, 1'b0);
      for (int y = 0; y <= 4; y++) drive("no_wrap_maxy", 32, y, 1'b1, 1'b0);

      // Centre net pixels (grey only when the net is built).
      nx_pl_x = 20; nx_pl_y = 300; nx_pc_x = 600; nx_pc_y = 300; nx_b_x = 100; nx_b_y = 100;
      strobe();
      drive("net_a", HRES / 2, 3, 1'b1, 1'b0);
      drive("net_b", HRES / 2 + 1, 3, 1'b1, 1'b0);
      drive("net_gap", HRES / 2, 10, 1'b1, 1'b0);
      drive("net_side", HRES / 2 + 2, 3, 1'b1, 1'b0);

      // Random traffic with occasional strobes and position changes.
      for (int i = 0; i < 400; i++) begin
         int px, py;
         bit nf;
         nf = ($urandom_range(0, 19) == 0);
         if (nf) begin
            nx_b_x = $urandom_range(0, 700);  nx_b_y = $urandom_range(0, 520);
            nx_pl_x = $urandom_range(0, 700); nx_pl_y = $urandom_range(0, 520);
            nx_pc_x = $urandom_range(0, 700); nx_pc_y = $urandom_range(0, 520);
         end
         case ($urandom_range(0, 3))
            0: begin px = m_b_x + $urandom_range(0, BS + 2) - 1; py = m_b_y + $urandom_range(0, BS + 2) - 1; end
            1: begin px = m_pl_x + $urandom_range(0, PW + 2) - 1; py = m_pl_y + $urandom_range(0, PH + 2) - 1; end
            default: begin px = $urandom_range(0, 700); py = $urandom_range(0, 520); end
         endcase
         if (px < 0) px = 0;
         if (py < 0) py = 0;
         px = px % (1 << XW);
         py = py % (1 << YW);
         drive("random", px, py, 1'($urandom_range(0, 7) != 0), nf);
      end

      repeat (4) @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
